// File: rtl/wb_commit_stage.sv
// Dual-issue writeback stage: holds the M->W register for both lanes, extracts
// load data, resolves WAW/exception kills and drives both regfile write ports.
module wb_commit_stage #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_W,
    input  logic             flush_W,
    input  logic             m_valid0,
    input  logic             m_valid1,
    input  logic             m_we0,
    input  logic             m_we1,
    input  logic [4:0]       m_wa0,
    input  logic [4:0]       m_wa1,
    input  logic [31:0]      m_wd0,
    input  logic [31:0]      m_wd1,
    input  logic             m_except0,
    input  logic             m_except1,
    input  logic             m_is_load0,
    input  logic [2:0]       m_ld_type0,
    input  logic [1:0]       m_addr_lo0,
    input  logic [31:0]      dmem_rdata,
    output logic             we3,
    output logic [4:0]       wa3,
    output logic [31:0]      wd3,
    output logic             we4,
    output logic [4:0]       wa4,
    output logic [31:0]      wd4,
    output logic [CNT_W-1:0] retired_cnt
);

    localparam logic [2:0] LD_LB  = 3'd0;
    localparam logic [2:0] LD_LBU = 3'd1;
    localparam logic [2:0] LD_LH  = 3'd2;
    localparam logic [2:0] LD_LHU = 3'd3;

    logic        w_v0, w_v1;
    logic        w_we0, w_we1;
    logic [4:0]  w_wa0, w_wa1;
    logic [31:0] w_wd0, w_wd1;
    logic        w_exc0, w_exc1;
    logic        w_is_load0;
    logic [2:0]  w_ld_type0;
    logic [1:0]  w_addr_lo0;

    logic        hold_flag;
    logic [31:0] hold_data;

    logic [31:0] ld_src;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic        ret0, ret1;
    logic [1:0]  retire_inc;

    // M->W pipeline register; the whole register freezes while stall_W is high
    always_ff @(posedge clk) begin
        if (rst) begin
            w_v0       <= 1'b0;
            w_v1       <= 1'b0;
            w_we0      <= 1'b0;
            w_we1      <= 1'b0;
            w_wa0      <= 5'd0;
            w_wa1      <= 5'd0;
            w_wd0      <= 32'd0;
            w_wd1      <= 32'd0;
            w_exc0     <= 1'b0;
            w_exc1     <= 1'b0;
            w_is_load0 <= 1'b0;
            w_ld_type0 <= 3'd0;
            w_addr_lo0 <= 2'd0;
        end else if (!stall_W) begin
            w_v0       <= m_valid0 & ~flush_W;
            w_v1       <= m_valid1 & ~flush_W & ~m_except0;
            w_we0      <= m_we0 & ~m_except0;
            w_we1      <= m_we1 & ~m_except1 & ~m_except0;
            w_wa0      <= m_wa0;
            w_wa1      <= m_wa1;
            w_wd0      <= m_wd0;
            w_wd1      <= m_wd1;
            w_exc0     <= m_except0;
            w_exc1     <= m_except1;
            w_is_load0 <= m_is_load0;
            w_ld_type0 <= m_ld_type0;
            w_addr_lo0 <= m_addr_lo0;
        end
    end

    // dmem_rdata is only valid in the first W cycle, so capture it on stall entry
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_flag <= 1'b0;
            hold_data <= 32'd0;
        end else if (!stall_W) begin
            hold_flag <= 1'b0;
        end else if (!hold_flag && w_v0 && w_is_load0) begin
            hold_flag <= 1'b1;
            hold_data <= dmem_rdata;
        end
    end

    always_comb begin
        ld_src = hold_flag ? hold_data : dmem_rdata;
        ld_byte = ld_src[7:0];
        case (w_addr_lo0)
            2'd0: ld_byte = ld_src[7:0];
            2'd1: ld_byte = ld_src[15:8];
            2'd2: ld_byte = ld_src[23:16];
            2'd3: ld_byte = ld_src[31:24];
            default: ld_byte = ld_src[7:0];
        endcase
        ld_half = w_addr_lo0[1] ? ld_src[31:16] : ld_src[15:0];
        case (w_ld_type0)
            LD_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
            LD_LBU:  ld_data = {24'd0, ld_byte};
            LD_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
            LD_LHU:  ld_data = {16'd0, ld_half};
            default: ld_data = ld_src;
        endcase
    end

    // Lane 1 is younger, so on a same-destination dual write it wins
    always_comb begin
        we4 = w_v1 & w_we1 & (w_wa1 != 5'd0);
        we3 = w_v0 & w_we0 & (w_wa0 != 5'd0) & ~(we4 & (w_wa1 == w_wa0));
        wa3 = w_wa0;
        wa4 = w_wa1;
        wd3 = w_is_load0 ? ld_data : w_wd0;
        wd4 = w_wd1;
    end

    assign ret0       = w_v0 & ~w_exc0;
    assign ret1       = w_v1 & ~w_exc1;
    assign retire_inc = {1'b0, ret0} + {1'b0, ret1};

    always_ff @(posedge clk) begin
        if (rst) begin
            retired_cnt <= '0;
        end else if (!stall_W) begin
            retired_cnt <= retired_cnt + CNT_W'(retire_inc);
        end
    end

endmodule

// File: tb/tb_wb_commit_stage.sv
// Directed bench for wb_commit_stage: expected port values are queued as each
// M-stage instruction is driven and compared once it sits in W.
module tb_wb_commit_stage;

    localparam int EXP_W = 76;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_W, flush_W;
    logic        m_valid0, m_valid1, m_we0, m_we1;
    logic [4:0]  m_wa0, m_wa1;
    logic [31:0] m_wd0, m_wd1;
    logic        m_except0, m_except1, m_is_load0;
    logic [2:0]  m_ld_type0;
    logic [1:0]  m_addr_lo0;
    logic [31:0] dmem_rdata;
    logic        we3, we4;
    logic [4:0]  wa3, wa4;
    logic [31:0] wd3, wd4;
    logic [31:0] retired_cnt;

    logic [EXP_W-1:0] exp_q[$];
    int               ret_q[$];
    int               n_checks = 0;
    int               n_errors = 0;
    logic [31:0]      exp_cnt = 32'd0;
    int               cur_ret = 0;

    wb_commit_stage #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .stall_W(stall_W), .flush_W(flush_W),
        .m_valid0(m_valid0), .m_valid1(m_valid1), .m_we0(m_we0), .m_we1(m_we1),
        .m_wa0(m_wa0), .m_wa1(m_wa1), .m_wd0(m_wd0), .m_wd1(m_wd1),
        .m_except0(m_except0), .m_except1(m_except1), .m_is_load0(m_is_load0),
        .m_ld_type0(m_ld_type0), .m_addr_lo0(m_addr_lo0), .dmem_rdata(dmem_rdata),
        .we3(we3), .wa3(wa3), .wd3(wd3), .we4(we4), .wa4(wa4), .wd4(wd4),
        .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_ports(input string tag, input logic [EXP_W-1:0] e);
        check({tag, ".we3"}, 32'(we3), 32'(e[75]));
        check({tag, ".wa3"}, 32'(wa3), 32'(e[74:70]));
        check({tag, ".wd3"}, wd3, e[69:38]);
        check({tag, ".we4"}, 32'(we4), 32'(e[37]));
        check({tag, ".wa4"}, 32'(wa4), 32'(e[36:32]));
        check({tag, ".wd4"}, wd4, e[31:0]);
    endtask

    task automatic set_lane0(input logic v, input logic we, input logic [4:0] wa,
                             input logic [31:0] wd, input logic exc);
        m_valid0 = v; m_we0 = we; m_wa0 = wa; m_wd0 = wd; m_except0 = exc;
    endtask

    task automatic set_lane1(input logic v, input logic we, input logic [4:0] wa,
                             input logic [31:0] wd, input logic exc);
        m_valid1 = v; m_we1 = we; m_wa1 = wa; m_wd1 = wd; m_except1 = exc;
    endtask

    task automatic set_load(input logic is_load, input logic [2:0] ty, input logic [1:0] off);
        m_is_load0 = is_load; m_ld_type0 = ty; m_addr_lo0 = off;
    endtask

    task automatic push_exp(input logic e_we3, input logic [4:0] e_wa3, input logic [31:0] e_wd3,
                            input logic e_we4, input logic [4:0] e_wa4, input logic [31:0] e_wd4,
                            input int ret);
        exp_q.push_back({e_we3, e_wa3, e_wd3, e_we4, e_wa4, e_wd4});
        ret_q.push_back(ret);
    endtask

    // One unstalled edge: the previous W contents retire, the driven slot enters W
    task automatic step_w(input string tag);
        logic [EXP_W-1:0] e;
        @(posedge clk);
        exp_cnt = exp_cnt + 32'(cur_ret);
        #1;
        e = exp_q.pop_front();
        cur_ret = ret_q.pop_front();
        check_ports(tag, e);
        check({tag, ".cnt"}, retired_cnt, exp_cnt);
    endtask

    task automatic load_step(input string tag, input logic [2:0] ty, input logic [1:0] off,
                             input logic [31:0] exp_wd);
        set_lane0(1'b1, 1'b1, 5'd9, 32'hDEAD_BEEF, 1'b0);
        set_lane1(1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        set_load(1'b1, ty, off);
        push_exp(1'b1, 5'd9, exp_wd, 1'b0, 5'd0, 32'd0, 1);
        step_w(tag);
    endtask

    initial begin
        logic [4:0]  r_wa0, r_wa1;
        logic [31:0] r_wd0, r_wd1;

        rst = 1'b1; stall_W = 1'b0; flush_W = 1'b0; dmem_rdata = 32'd0;
        set_lane0(1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        set_lane1(1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        set_load(1'b0, 3'd0, 2'd0);
        repeat (2) @(posedge clk);
        #1;
        check_ports("reset", '0);
        check("reset.cnt", retired_cnt, 32'd0);
        rst = 1'b0;

        set_lane0(1'b1, 1'b1, 5'd3, 32'h11, 1'b0);
        set_lane1(1'b1, 1'b1, 5'd5, 32'h22, 1'b0);
        push_exp(1'b1, 5'd3, 32'h11, 1'b1, 5'd5, 32'h22, 2);
        step_w("dual_alu");

        set_lane0(1'b1, 1'b1, 5'd7, 32'hA, 1'b0);
        set_lane1(1'b1, 1'b1, 5'd7, 32'hB, 1'b0);
        push_exp(1'b0, 5'd7, 32'hA, 1'b1, 5'd7, 32'hB, 2);
        step_w("waw");

        set_lane0(1'b1, 1'b1, 5'd0, 32'h1, 1'b0);
        set_lane1(1'b1, 1'b1, 5'd0, 32'h2, 1'b0);
        push_exp(1'b0, 5'd0, 32'h1, 1'b0, 5'd0, 32'h2, 2);
        step_w("r0_dest");

        r_wa0 = 5'($urandom_range(1, 15));
        r_wa1 = 5'($urandom_range(16, 31));
        r_wd0 = $urandom;
        r_wd1 = $urandom;
        set_lane0(1'b1, 1'b1, r_wa0, r_wd0, 1'b0);
        set_lane1(1'b1, 1'b1, r_wa1, r_wd1, 1'b0);
        push_exp(1'b1, r_wa0, r_wd0, 1'b1, r_wa1, r_wd1, 2);
        step_w("rand_alu");

        dmem_rdata = 32'h8899AABB;
        load_step("lb0",  3'd0, 2'd0, 32'hFFFFFFBB);
        load_step("lbu2", 3'd1, 2'd2, 32'h00000099);
        load_step("lb3",  3'd0, 2'd3, 32'hFFFFFF88);
        load_step("lh2",  3'd2, 2'd2, 32'hFFFF8899);
        load_step("lh3",  3'd2, 2'd3, 32'hFFFF8899);
        load_step("lhu0", 3'd3, 2'd0, 32'h0000AABB);
        load_step("lw",   3'd4, 2'd0, 32'h8899AABB);
        load_step("ld7",  3'd7, 2'd1, 32'h8899AABB);

        // LW stalled in W while the memory word goes away
        load_step("lw_pre_stall", 3'd4, 2'd0, 32'h8899AABB);
        stall_W = 1'b1;
        set_lane0(1'b1, 1'b1, 5'd4, 32'h55, 1'b0);
        set_load(1'b0, 3'd0, 2'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 dmem_rdata = 32'd0;
            #1;
            check_ports($sformatf("stall%0d", i),
                        {1'b1, 5'd9, 32'h8899AABB, 1'b0, 5'd0, 32'd0});
            check($sformatf("stall%0d.cnt", i), retired_cnt, exp_cnt);
        end
        stall_W = 1'b0;
        push_exp(1'b1, 5'd4, 32'h55, 1'b0, 5'd0, 32'd0, 1);
        step_w("post_stall");
        dmem_rdata = 32'h12345678;
        load_step("lw_after_hold", 3'd4, 2'd0, 32'h12345678);

        set_lane0(1'b1, 1'b1, 5'd6, 32'h66, 1'b1);
        set_lane1(1'b1, 1'b1, 5'd8, 32'h88, 1'b0);
        set_load(1'b0, 3'd0, 2'd0);
        push_exp(1'b0, 5'd6, 32'h66, 1'b0, 5'd8, 32'h88, 0);
        step_w("exc0_kill");

        set_lane0(1'b1, 1'b1, 5'd10, 32'h1010, 1'b0);
        set_lane1(1'b1, 1'b1, 5'd11, 32'h1111, 1'b1);
        push_exp(1'b1, 5'd10, 32'h1010, 1'b0, 5'd11, 32'h1111, 1);
        step_w("exc1_kill");

        flush_W = 1'b1;
        set_lane0(1'b1, 1'b1, 5'd12, 32'h1212, 1'b0);
        set_lane1(1'b1, 1'b1, 5'd13, 32'h1313, 1'b0);
        push_exp(1'b0, 5'd12, 32'h1212, 1'b0, 5'd13, 32'h1313, 0);
        step_w("flush");
        flush_W = 1'b0;

        set_lane0(1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        set_lane1(1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        push_exp(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 0);
        step_w("idle");

        // Reset while a load is stalled and its data is being held
        load_step("lw_pre_rst", 3'd4, 2'd0, 32'h12345678);
        stall_W = 1'b1;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check_ports("rst_in_stall", '0);
        check("rst_in_stall.cnt", retired_cnt, 32'd0);
        rst = 1'b0;
        stall_W = 1'b0;
        exp_cnt = 32'd0;
        cur_ret = 0;
        dmem_rdata = 32'h0F0F0F0F;
        load_step("lw_after_rst", 3'd4, 2'd0, 32'h0F0F0F0F);
        set_lane0(1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        set_load(1'b0, 3'd0, 2'd0);
        push_exp(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 0);
        step_w("final");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
